mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 15 +
 rtl/mult_arbiter.sv | 74 +++++++
 tb/tb_mult_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request/operand bus and datapath control bundle for mult_arbiter.
interface mult_arbiter_if #(parameter int W = 16);
  logic req0, req1, eqZ;
  logic [W-1:0] a0, b0, a1, b1, data_in;
  logic ldA, ldB, ldP, clrP, decB;
  logic gnt0, gnt1, done0, done1, busy;
  modport master (
    output req0, req1, a0, b0, a1, b1, eqZ,
    input data_in, ldA, ldB, ldP, clrP, decB, gnt0, gnt1, done0, done1, busy
  );
  modport slave (
    input req0, req1, a0, b0, a1, b1, eqZ,
    output data_in, ldA, ldB, ldP, clrP, decB, gnt0, gnt1, done0, done1, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester arbiter sequencing a repeated-add multiplier datapath.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module mult_arbiter #(parameter int W = 16) (
  input logic clk,
  input logic rst,
  mult_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LDA, LDB, ACC, FIN} state_t;
  state_t state, state_n;
  logic g0, g1, pick1, any_req;
  logic [W-1:0] a, b;
  assign any_req = bus.req0 | bus.req1;
`ifdef MULT_ARB_RR_EN
  logic last1;
  assign pick1 = bus.req1 & (~bus.req0 | ~last1);
  always_ff @(posedge clk)
    if (rst) last1 <= 1'b1;
    else if (state == IDLE && any_req) last1 <= pick1;
`else
  assign pick1 = bus.req1 & ~bus.req0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Grant is latched at the IDLE decision and held until FIN completes.
  always_ff @(posedge clk)
    if (rst) begin
      g0 <= 1'b0;
      g1 <= 1'b0;
    end else if (state == IDLE && any_req) begin
      g0 <= ~pick1;
      g1 <= pick1;
    end else if (state == FIN) begin
      g0 <= 1'b0;
      g1 <= 1'b0;
    end
  assign a = g1 ? bus.a1 : bus.a0;
  assign b = g1 ? bus.b1 : bus.b0;
  always_comb begin
    state_n = state;
    bus.data_in = '0;
    bus.ldA = 1'b0;
    bus.ldB = 1'b0;
    bus.ldP = 1'b0;
    bus.clrP = 1'b0;
    bus.decB = 1'b0;
    case (state)
      IDLE: state_n = any_req ? LDA : IDLE;
      LDA: begin
        bus.data_in = a;
        bus.ldA = 1'b1;
        state_n = LDB;
      end
      LDB: begin
        bus.data_in = b;
        bus.ldB = 1'b1;
        bus.clrP = 1'b1;
        state_n = ACC;
      end
      ACC: begin
        bus.ldP = ~bus.eqZ;
        bus.decB = ~bus.eqZ;
        state_n = bus.eqZ ? FIN : ACC;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;
  assign bus.done0 = (state == FIN) & g0;
  assign bus.done1 = (state == FIN) & g1;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: table-driven and scoreboarded bench for mult_arbiter with a behavioural A/B/P datapath.
module tb_mult_arbiter;
  localparam int W = 16;
`ifdef MULT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mult_arbiter_if #(.W(W)) bus();
  mult_arbiter #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [W-1:0] ra = '0, rb = '0;
  logic [2*W-1:0] rp = '0;
  logic last1 = 1'b1;
  logic pd = 1'b0;

  typedef struct {logic who; logic [2*W-1:0] prod;} exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    logic who;
    int lat, ldp;
  } vec_t;
  vec_t tv[6];

  assign bus.eqZ = (rb == '0);
  always @(posedge clk) begin
    if (bus.ldA) ra <= bus.data_in;
    if (bus.ldB) rb <= bus.data_in;
    else if (bus.decB) rb <= rb - 1'b1;
    if (bus.clrP) rp <= '0;
    else if (bus.ldP) rp <= rp + (2*W)'(ra);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic logic pick(input logic r0, input logic r1);
    return RR ? (r1 & (~r0 | ~last1)) : (r1 & ~r0);
  endfunction

  function automatic logic [63:0] outs();
    return {bus.data_in, bus.ldA, bus.ldB, bus.ldP, bus.clrP, bus.decB,
            bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
      check("ld_exclusive", ($countones({bus.ldA, bus.ldB, bus.ldP}) > 1), 0);
      check("data_in_idle", (!bus.ldA && !bus.ldB) ? bus.data_in : '0, 0);
      check("done_width", pd & (bus.done0 | bus.done1), 0);
      check("busy_vs_gnt", bus.busy, bus.gnt0 | bus.gnt1);
      if (bus.done0 | bus.done1) begin
        check("done_matches_gnt", {bus.done0, bus.done1}, {bus.gnt0, bus.gnt1});
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("done_who", bus.done1, e.who);
          check("product", rp, e.prod);
        end
      end
    end
    pd = bus.done0 | bus.done1;
  end

  // Called at a negedge one cycle before the IDLE sample edge; returns at the done negedge.
  task automatic job(input logic r0, input logic r1, input logic who, input int exp_lat, input int exp_ldp);
    int lat = -1;
    int nldp = 0;
    bus.req0 = r0;
    bus.req1 = r1;
    sb.push_back('{who, who ? prod(bus.a1, bus.b1) : prod(bus.a0, bus.b0)});
    last1 = who;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.ldP) nldp++;
      if (bus.done0 | bus.done1) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("ldP_count", nldp, exp_ldp);
  endtask

  task automatic set_ops(input logic [W-1:0] x0, input logic [W-1:0] y0, input logic [W-1:0] x1, input logic [W-1:0] y1);
    bus.a0 = x0;
    bus.b0 = y0;
    bus.a1 = x1;
    bus.b1 = y1;
  endtask

  task automatic idle_gap();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, nd;
    logic r0, r1, who;
    logic [1:0] r;
    tv[0] = '{1'b1, 1'b0, 16'd5, 16'd3, 16'd0, 16'd0, 1'b0, 7, 3};
    tv[1] = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd9, 16'd0, 1'b1, 4, 0};
    tv[2] = '{1'b1, 1'b0, 16'd0, 16'd4, 16'd7, 16'd7, 1'b0, 8, 4};
    tv[3] = '{1'b0, 1'b1, 16'd11, 16'd9, 16'hFFFF, 16'd2, 1'b1, 6, 2};
    tv[4] = '{1'b1, 1'b1, 16'd3, 16'd1, 16'd4, 16'd5, 1'b0, 5, 1};
    tv[5] = '{1'b1, 1'b1, 16'd6, 16'd2, 16'd8, 16'd3, RR, RR ? 7 : 6, RR ? 3 : 2};
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    set_ops('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    last1 = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs(), 0);
    for (int i = 0; i < 6; i++) begin
      set_ops(tv[i].a0, tv[i].b0, tv[i].a1, tv[i].b1);
      job(tv[i].r0, tv[i].r1, tv[i].who, tv[i].lat, tv[i].ldp);
      idle_gap();
    end
    // Simultaneous requests held high from reset: two back-to-back jobs.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last1 = 1'b1;
    set_ops(16'd2, 16'd1, 16'd3, 16'd2);
    job(1'b1, 1'b1, 1'b0, 5, 1);
    job(1'b1, 1'b1, RR, RR ? 7 : 6, RR ? 2 : 1);
    idle_gap();
    // Reset during ACC of a b=6 job aborts without a done pulse.
    set_ops(16'd3, 16'd6, 16'd0, 16'd0);
    bus.req0 = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_in_acc", bus.ldP, 1);
    rst = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("abort_outputs", outs(), 0);
    rst = 1'b0;
    last1 = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(bus.done0 | bus.done1);
    end
    check("abort_no_done", nd, 0);
    // req0 dropped during LDB still completes with a single done0.
    set_ops(16'd7, 16'd2, 16'd1, 16'd1);
    bus.req0 = 1'b1;
    sb.push_back('{1'b0, prod(16'd7, 16'd2)});
    last1 = 1'b0;
    lat = -1;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 2) bus.req0 = 1'b0;
      if (bus.done0) begin
        nd++;
        if (lat < 0) lat = k;
      end
    end
    check("drop_latency", lat, 6);
    check("drop_done_count", nd, 1);
    check("drop_idle", bus.busy, 0);
    for (int i = 0; i < 20; i++) begin
      r = 2'($urandom_range(1, 3));
      r0 = r[0];
      r1 = r[1];
      who = pick(r0, r1);
      set_ops(W'($urandom), W'($urandom_range(0, 7)), W'($urandom), W'($urandom_range(0, 7)));
      job(r0, r1, who, 4 + int'(who ? bus.b1 : bus.b0), int'(who ? bus.b1 : bus.b0));
      idle_gap();
    end
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
